// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants: CRC-32 parameters, MII preamble/SFD nibbles
// and the receive FSM state encoding.
package eth_pkg;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_e;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational byte-wide step of the reflected CRC-32 (LSB of data first).
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] crc_v;

    always_comb begin
        crc_v = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_v[0] ^ data[i]) begin
                crc_v = (crc_v >> 1) ^ CRC_POLY_REFL;
            end else begin
                crc_v = crc_v >> 1;
            end
        end
        crc_out = crc_v;
    end

endmodule

// File: rtl/mac_rx_mii.sv
// MII receive MAC: strips preamble/SFD, pairs nibbles into bytes and delivers them
// one byte late so the final byte can carry last/err/crc_ok status.
module mac_rx_mii
    import eth_pkg::*;
#(
    parameter int MAX_LEN = 1536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mii_rx_dv,
    input  logic        mii_rx_er,
    input  logic [3:0]  mii_rxd,
    output logic        rx_vld,
    output logic        rx_last,
    output logic        rx_err,
    output logic        rx_crc_ok,
    output logic        rx_busy,
    output logic [10:0] rx_addr,
    output logic [7:0]  rx_data,
    output rx_state_e   dbg_state
);

    localparam int CNT_W = $clog2(MAX_LEN + 2);

    rx_state_e        state_q, state_d;
    logic [3:0]       nib_q, nib_d;
    logic             half_q, half_d;
    logic [7:0]       pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic             err_q, err_d;

    logic             vld_q, vld_d;
    logic             last_q, last_d;
    logic             rerr_q, rerr_d;
    logic             ok_q, ok_d;
    logic             busy_q, busy_d;
    logic [10:0]      addr_q, addr_d;
    logic [7:0]       data_q, data_d;

    logic [31:0]      crc_next;
    logic [CNT_W-1:0] pend_idx;

    // CRC advances only when the pending byte is actually delivered.
    eth_crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (pend_q),
        .crc_out (crc_next)
    );

    assign pend_idx = cnt_q - CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        nib_d      = nib_q;
        half_d     = half_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        err_d      = err_q;
        vld_d      = 1'b0;
        last_d     = 1'b0;
        rerr_d     = 1'b0;
        ok_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        busy_d     = (state_q == DATA);

        case (state_q)
            WAIT_IDLE: begin
                if (!mii_rx_dv) state_d = IDLE;
            end
            IDLE: begin
                if (mii_rx_dv) state_d = (mii_rxd == PREAMBLE_NIB) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!mii_rx_dv) begin
                    state_d = IDLE;
                end else if (mii_rxd == SFD_NIB) begin
                    state_d    = DATA;
                    half_d     = 1'b0;
                    pend_vld_d = 1'b0;
                    cnt_d      = '0;
                    crc_d      = CRC_INIT;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                end else if (mii_rxd != PREAMBLE_NIB) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (!mii_rx_dv) begin
                    // End of frame: flush pending as the last byte; a dangling nibble is an error.
                    state_d    = IDLE;
                    half_d     = 1'b0;
                    pend_vld_d = 1'b0;
                    if (pend_vld_q) begin
                        vld_d  = 1'b1;
                        last_d = 1'b1;
                        rerr_d = err_q | half_q;
                        ok_d   = (crc_next == CRC_RESIDUE);
                        data_d = pend_q;
                        addr_d = 11'(pend_idx);
                        crc_d  = crc_next;
                    end
                end else begin
                    if (mii_rx_er) err_d = 1'b1;
                    if (!half_q) begin
                        nib_d  = mii_rxd;
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (pend_vld_q) begin
                            vld_d  = 1'b1;
                            data_d = pend_q;
                            addr_d = 11'(pend_idx);
                            crc_d  = crc_next;
                        end
                        if (cnt_q == CNT_W'(MAX_LEN)) begin
                            state_d    = DROP;
                            pend_vld_d = 1'b0;
                            last_d     = pend_vld_q;
                            rerr_d     = pend_vld_q;
                            ok_d       = pend_vld_q && (crc_next == CRC_RESIDUE);
                        end else begin
                            pend_d     = {mii_rxd, nib_q};
                            pend_vld_d = 1'b1;
                            cnt_d      = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            DROP: begin
                if (!mii_rx_dv) state_d = IDLE;
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT_IDLE;
            nib_q      <= '0;
            half_q     <= 1'b0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            crc_q      <= CRC_INIT;
            err_q      <= 1'b0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
            rerr_q     <= 1'b0;
            ok_q       <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            nib_q      <= nib_d;
            half_q     <= half_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            err_q      <= err_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
            rerr_q     <= rerr_d;
            ok_q       <= ok_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign rx_vld    = vld_q;
    assign rx_last   = last_q;
    assign rx_err    = rerr_q;
    assign rx_crc_ok = ok_q;
    assign rx_busy   = busy_q;
    assign rx_addr   = addr_q;
    assign rx_data   = data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_rx_mii.sv
// Randomized frame bench for mac_rx_mii: a frame-level model fills an expected
// queue, a negedge monitor pops and compares every delivered byte.
module tb_mac_rx_mii;
    import eth_pkg::*;

    localparam int MAX_LEN = 1536;

    logic        clk = 1'b0;
    logic        reset;
    logic        mii_rx_dv;
    logic        mii_rx_er;
    logic [3:0]  mii_rxd;
    logic        rx_vld, rx_last, rx_err, rx_crc_ok, rx_busy;
    logic [10:0] rx_addr;
    logic [7:0]  rx_data;
    rx_state_e   dbg_state;

    always #5 clk = ~clk;

    mac_rx_mii #(.MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .mii_rx_dv (mii_rx_dv),
        .mii_rx_er (mii_rx_er),
        .mii_rxd   (mii_rxd),
        .rx_vld    (rx_vld),
        .rx_last   (rx_last),
        .rx_err    (rx_err),
        .rx_crc_ok (rx_crc_ok),
        .rx_busy   (rx_busy),
        .rx_addr   (rx_addr),
        .rx_data   (rx_data),
        .dbg_state (dbg_state)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [21:0] exp_q[$];     // {addr, data, last, err, crc_ok}
    logic [7:0]  tx_q[$];
    bit          mon_en = 1'b0;
    bit          exp_busy_tail = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Standard Ethernet FCS (with final inversion) over tx_q[0..n-1].
    function automatic logic [31:0] crc32_of(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ tx_q[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
                else                   c = c >> 1;
            end
        end
        return ~c;
    endfunction

    // True when the last four of the first n bytes are a correct FCS for the rest.
    function automatic bit fcs_match(input int n);
        if (n < 4) return 1'b0;
        return crc32_of(n - 4) == {tx_q[n-1], tx_q[n-2], tx_q[n-3], tx_q[n-4]};
    endfunction

    task automatic build_frame(input int n);
        logic [31:0] c;
        tx_q.delete();
        if (n < 4) begin
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
        end else begin
            for (int i = 0; i < n - 4; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            c = crc32_of(n - 4);
            tx_q.push_back(c[7:0]);
            tx_q.push_back(c[15:8]);
            tx_q.push_back(c[23:16]);
            tx_q.push_back(c[31:24]);
        end
    endtask

    task automatic push_exp(input int i, input bit last, input bit err, input bit ok);
        exp_q.push_back({11'(i), tx_q[i], last, err, ok});
    endtask

    task automatic model_frame(input int n, input bit odd, input int er_byte, input int rst_byte);
        int n_emit;
        bit err;
        bit ok;
        if (rst_byte >= 0) begin
            // Bytes already delivered before the reset edge; the pending one is lost.
            for (int i = 0; i < rst_byte - 1; i++) push_exp(i, 1'b0, 1'b0, 1'b0);
            return;
        end
        if (n == 0) return;
        if (n > MAX_LEN) begin
            n_emit = MAX_LEN;
            err    = 1'b1;
        end else begin
            n_emit = n;
            err    = odd || (er_byte >= 0 && er_byte < n);
        end
        ok = fcs_match(n_emit);
        for (int i = 0; i < n_emit; i++) begin
            push_exp(i, i == n_emit - 1, (i == n_emit - 1) && err, (i == n_emit - 1) && ok);
        end
    endtask

    task automatic drive(input logic dv, input logic er, input logic [3:0] d, input logic rst);
        @(posedge clk);
        #1;
        mii_rx_dv = dv;
        mii_rx_er = er;
        mii_rxd   = d;
        reset     = rst;
    endtask

    task automatic send_frame(input int n, input bit odd, input int er_byte,
                              input int rst_byte, input int ifg);
        bit tail;
        model_frame(n, odd, er_byte, rst_byte);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, (i == 15) ? SFD_NIB : PREAMBLE_NIB, 1'b0);
            if (i == 0) check("busy_tail_prev", 32'(rx_busy), 32'(exp_busy_tail));
            if (i == 1) check("busy_gap", 32'(rx_busy), 0);
        end
        for (int i = 0; i < n; i++) begin
            drive(1'b1, i == er_byte, tx_q[i][3:0], i == rst_byte);
            if (i == 0) check("busy_after_sfd", 32'(rx_busy), 1);
            drive(1'b1, 1'b0, tx_q[i][7:4], 1'b0);
            if (i == rst_byte) begin
                check("rst_vld", 32'(rx_vld), 0);
                check("rst_busy", 32'(rx_busy), 0);
                check("rst_addr", 32'(rx_addr), 0);
                check("rst_data", 32'(rx_data), 0);
            end
        end
        if (odd) begin
            drive(1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
            if (n == 0) check("busy_after_sfd", 32'(rx_busy), 1);
        end
        tail = (rst_byte < 0) && (n <= MAX_LEN);
        for (int k = 0; k < ifg; k++) begin
            drive(1'b0, 1'b0, 4'h0, 1'b0);
            if (k == 1) check("busy_tail", 32'(rx_busy), 32'(tail));
        end
        exp_busy_tail = (ifg == 1) ? tail : 1'b0;
    endtask

    // Malformed preamble: the frame must be dropped without any strobe.
    task automatic bad_frame(input logic [3:0] first, input logic [3:0] bad);
        drive(1'b1, 1'b0, first, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, PREAMBLE_NIB, 1'b0);
        drive(1'b1, 1'b0, bad, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, PREAMBLE_NIB, 1'b0);
        drive(1'b1, 1'b0, SFD_NIB, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
        check("drop_busy", 32'(rx_busy), 0);
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        exp_busy_tail = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rx_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got addr %0d data 0x%0h last %0b, expected no strobe",
                             rx_addr, rx_data, rx_last);
                end else begin
                    check("strobe{addr,data,last,err,ok}",
                          32'({rx_addr, rx_data, rx_last, rx_err, rx_crc_ok}), 32'(exp_q.pop_front()));
                end
            end else begin
                check("quals_idle", 32'({rx_vld, rx_last, rx_err, rx_crc_ok}), 0);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        mii_rx_dv = 1'b0;
        mii_rx_er = 1'b0;
        mii_rxd   = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_vld", 32'(rx_vld), 0);
        check("reset_last_err_ok", 32'({rx_last, rx_err, rx_crc_ok}), 0);
        check("reset_busy", 32'(rx_busy), 0);
        check("reset_addr", 32'(rx_addr), 0);
        check("reset_data", 32'(rx_data), 0);
        check("reset_state", 32'(dbg_state), 32'(WAIT_IDLE));
        mon_en = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 1'b0);

        // Good 64-byte frame.
        build_frame(64);
        send_frame(64, 1'b0, -1, -1, 3);
        // Single bit error in byte 20.
        build_frame(64);
        tx_q[20] = tx_q[20] ^ 8'h01;
        send_frame(64, 1'b0, -1, -1, 2);
        // PHY error during byte 30.
        build_frame(64);
        send_frame(64, 1'b0, 30, -1, 1);
        // Trailing odd nibble.
        build_frame(64);
        send_frame(64, 1'b1, -1, -1, 1);
        // Oversize, then a good frame after a single idle cycle.
        build_frame(1600);
        send_frame(1600, 1'b0, -1, -1, 1);
        build_frame(64);
        send_frame(64, 1'b0, -1, -1, 1);
        // Reset during byte 10 with dv held high, then a good frame.
        build_frame(64);
        send_frame(64, 1'b0, -1, 10, 2);
        build_frame(64);
        send_frame(64, 1'b0, -1, -1, 1);
        // Exactly MAX_LEN bytes is still accepted.
        build_frame(MAX_LEN);
        send_frame(MAX_LEN, 1'b0, -1, -1, 1);
        // dv drops before any complete byte.
        tx_q.delete();
        send_frame(0, 1'b1, -1, -1, 2);
        // Malformed preambles.
        bad_frame(PREAMBLE_NIB, 4'h3);
        bad_frame(SFD_NIB, PREAMBLE_NIB);
        // Randomized frames.
        for (int f = 0; f < 10; f++) begin
            int n;
            int er;
            n  = $urandom_range(1, 120);
            er = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 119)) : -1;
            build_frame(n);
            if ($urandom_range(0, 2) == 0) tx_q[$urandom_range(0, n - 1)] ^= 8'($urandom_range(1, 255));
            send_frame(n, $urandom_range(0, 3) == 0, er, -1, $urandom_range(1, 3));
        end

        repeat (6) drive(1'b0, 1'b0, 4'h0, 1'b0);
        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_rx_mii.md
MAC_RX_MII -- requirements
Module: mac_rx_mii

Interface
REQ-001 Parameter MAX_LEN, default 1536: maximum accepted frame length in bytes, including FCS.
REQ-002 clk  in  1  MII receive clock; one nibble is sampled per rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 mii_rx_dv  in  1  MII receive data valid.
REQ-005 mii_rx_er  in  1  MII receive error.
REQ-006 mii_rxd  in  4  MII receive nibble; the low nibble of each byte arrives first.
REQ-007 rx_vld  out  1  one-cycle strobe: a frame byte is present on rx_data/rx_addr.
REQ-008 rx_last  out  1  qualifies rx_vld: this byte is the final byte of the frame.
REQ-009 rx_err  out  1  qualifies rx_vld&rx_last: the frame had a PHY error, an odd nibble count, or was oversize.
REQ-010 rx_crc_ok  out  1  qualifies rx_vld&rx_last: the CRC over all bytes, including FCS, gives a good residue.
REQ-011 rx_busy  out  1  high while a frame is being delivered.
REQ-012 rx_addr  out  11  byte index within the frame; 0 is the first destination-MAC byte.
REQ-013 rx_data  out  8  frame byte.

Function
REQ-014 FSM states: WAIT_IDLE, IDLE, PREAMBLE, DATA, DROP.
- WAIT_IDLE->IDLE when dv=0.
- IDLE->PREAMBLE when dv&rxd==5; IDLE->DROP when dv&rxd!=5.
- PREAMBLE: stays on rxd==5; ->DATA on rxd==D (SFD); ->DROP on any other nibble; ->IDLE when dv=0.
- DATA->IDLE when dv=0, after the final byte is emitted; DATA->DROP on oversize.
- DROP->IDLE when dv=0.
REQ-015 In DATA, nibbles pair into bytes as {second,first}; each complete byte goes into a one-byte pending register.
REQ-016 When a new byte completes and pending is valid, the block emits pending with rx_vld=1 and rx_last=0 on the next cycle. Latency is one byte time (2 clk).
REQ-017 On dv falling in DATA with pending valid, the block emits pending on the next cycle with rx_vld=1, rx_last=1, and rx_err/rx_crc_ok valid.
REQ-018 If dv falls before any complete byte: no rx_vld, no rx_last, and rx_busy drops.
REQ-019 rx_addr starts at 0 for each frame and increments by 1 per emitted byte; it holds its value between strobes.
REQ-020 CRC-32 (poly 04C11DB7, reflected, init FFFFFFFF) covers every emitted byte. rx_crc_ok = (CRC register after the last byte == 32'hDEBB20E3).
REQ-021 Error sources are ORed into a sticky flag that is cleared at SFD:
- mii_rx_er while dv in DATA;
- odd nibble count at dv fall (the dangling nibble is discarded);
- oversize.
REQ-022 Oversize: when byte number MAX_LEN+1 completes, the block emits pending (addr MAX_LEN-1) with rx_last=1 and rx_err=1, then enters DROP. No further rx_vld occurs until the next SFD.
REQ-023 rx_busy rises on the cycle after SFD is detected. It falls on the cycle after the rx_last strobe, or after dv falls when no byte was emitted.
REQ-024 rx_last, rx_err and rx_crc_ok are 0 whenever rx_vld=0.
REQ-025 All outputs are registered.
REQ-026 A dv drop lasting a single cycle between frames is sufficient for the next preamble to be accepted.

Reset
REQ-027 Reset clears rx_vld, rx_last, rx_err, rx_crc_ok, rx_busy, rx_addr and rx_data to 0, invalidates pending, presets the CRC register, and forces state WAIT_IDLE.
REQ-028 Reset asserted mid-frame aborts the frame with no rx_last. After release, nothing is emitted until dv has been low and a new preamble+SFD arrives.

Structure
REQ-029 Package eth_pkg holds:
- the CRC polynomial, init value and residue (DEBB20E3);
- preamble and SFD nibble constants;
- the FSM state enum.
REQ-030 Sub-module eth_crc32_d8 is a combinational byte-wide CRC next-state function (crc_in, data -> crc_out); it is instantiated once.

Verification
REQ-031 7x55 preamble, D5 SFD, then a 64-byte frame with valid FCS -> 64 strobes with addr 0..63 and data matching; addr 63 has last=1, crc_ok=1, err=0; busy low 1 cycle after.
REQ-032 Same frame with bit 0 of byte 20 flipped -> last at addr 63 with crc_ok=0, err=0.
REQ-033 mii_rx_er high for 1 cycle during byte 30 -> all 64 bytes delivered; last has err=1.
REQ-034 Frame ending with one extra nibble -> last at addr 63, err=1, the extra nibble is not emitted.
REQ-035 1600-byte frame with MAX_LEN=1536 -> last at addr 1535 with err=1, no strobes after that, busy low; a following good frame is received correctly.
REQ-036 Reset pulse during byte 10 and released with dv still high -> no strobes for the remainder of that frame; the next frame is delivered from addr 0 with crc_ok=1.
